// File: rtl/anton_neopixel_stream_sequencer_if.sv
// Register/stream bundle between the APB register block, the frame
// sequencer and the bit-pattern/serialiser logic.
// master: register-block side (drives control, observes the stream).
// slave:  sequencer side (consumes control, drives the stream).
interface anton_neopixel_stream_sequencer_if #(
  parameter int BUFFER_BITS  = 4,
  parameter int PATTERN_BITS = 3
);

  logic                    reg_ctrl_init;
  logic                    reg_ctrl_run;
  logic                    reg_ctrl_loop;
  logic                    reg_ctrl_limit;
  logic                    reg_ctrl_32bit;
  logic [12:0]             reg_max;

  logic [1:0]              state;
  logic [PATTERN_BITS-1:0] bit_pattern_index;
  logic [4:0]              pixel_bit_index;
  logic [BUFFER_BITS-1:0]  pixel_index;
  logic [BUFFER_BITS-1:0]  pixel_index_max;
  logic                    stream_output;
  logic                    stream_reset;
  logic                    stream_pattern_of;
  logic                    stream_bit_of;
  logic                    stream_pixel_of;
  logic                    frame_done;
  logic [15:0]             frame_count;

  modport master (
    output reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop, reg_ctrl_limit,
           reg_ctrl_32bit, reg_max,
    input  state, bit_pattern_index, pixel_bit_index, pixel_index,
           pixel_index_max, stream_output, stream_reset, stream_pattern_of,
           stream_bit_of, stream_pixel_of, frame_done, frame_count
  );

  modport slave (
    input  reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop, reg_ctrl_limit,
           reg_ctrl_32bit, reg_max,
    output state, bit_pattern_index, pixel_bit_index, pixel_index,
           pixel_index_max, stream_output, stream_reset, stream_pattern_of,
           stream_bit_of, stream_pixel_of, frame_done, frame_count
  );

endinterface

// File: rtl/anton_neopixel_stream_sequencer.sv
// NeoPixel frame sequencer in the 7 MHz pixel clock domain.
// Owns the IDLE/TRANSMIT/RESET state machine and the nested stream
// counters (sub-bit step, bit within pixel, pixel within frame) plus the
// inter-frame reset gap counter.
// Optional feature: define ANTON_STREAM_FRAME_COUNTER_EN to implement the
// 16-bit completed-frame counter; otherwise frame_count is tied to zero.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 15
`endif

module anton_neopixel_stream_sequencer #(
  parameter int BUFFER_END    = `BUFFER_END_DEFAULT,
  parameter int PATTERN_STEPS = 8,
  parameter int RESET_CYCLES  = 350
) (
  input  logic                                 clk7mhz,
  input  logic                                 rstn,
  anton_neopixel_stream_sequencer_if.slave     bus
);

  localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1);
  localparam int PATTERN_BITS = $clog2(PATTERN_STEPS);
  localparam int RESET_BITS   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [PATTERN_BITS-1:0] PATTERN_LAST   = PATTERN_BITS'(PATTERN_STEPS - 1);
  localparam logic [RESET_BITS-1:0]   RESET_LAST     = RESET_BITS'(RESET_CYCLES - 1);
  localparam logic [12:0]             BUFFER_END_REG = 13'(BUFFER_END);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRANSMIT = 2'd1,
    ST_RESET    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    run_q;
  logic [PATTERN_BITS-1:0] pattern_q, pattern_d;
  logic [4:0]              bit_q, bit_d;
  logic [BUFFER_BITS-1:0]  pixel_q, pixel_d;
  logic [BUFFER_BITS-1:0]  pixel_max_q, pixel_max_d;
  logic                    mode32_q, mode32_d;
  logic [RESET_BITS-1:0]   gap_q, gap_d;
  logic                    frame_done_q, frame_done_d;

  logic                    active;
  logic                    tx_active;
  logic                    gap_active;
  logic                    pattern_of;
  logic                    bit_of;
  logic                    pixel_of;
  logic                    start;
  logic                    gap_end;
  logic [4:0]              bit_last;
  logic [12:0]             limit_wide;
  logic [BUFFER_BITS-1:0]  limit_eff;

  // Stream qualifiers, overflow strobes and the clamped frame limit.
  always_comb begin
    active     = bus.reg_ctrl_run && !bus.reg_ctrl_init;
    tx_active  = (state_q == ST_TRANSMIT) && active;
    gap_active = (state_q == ST_RESET) && active;
    bit_last   = mode32_q ? 5'd31 : 5'd23;
    pattern_of = tx_active && (pattern_q == PATTERN_LAST);
    bit_of     = pattern_of && (bit_q == bit_last);
    pixel_of   = bit_of && (pixel_q == pixel_max_q);
    start      = active && (bus.reg_ctrl_loop || !run_q);
    gap_end    = gap_active && (gap_q == RESET_LAST);
    limit_wide = (bus.reg_ctrl_limit && (bus.reg_max < BUFFER_END_REG)) ? bus.reg_max
                                                                        : BUFFER_END_REG;
    limit_eff  = BUFFER_BITS'(limit_wide);
  end

  // Next-state and counter logic; everything holds unless the stream is active.
  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    bit_d        = bit_q;
    pixel_d      = pixel_q;
    pixel_max_d  = pixel_max_q;
    mode32_d     = mode32_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_TRANSMIT;
          pattern_d   = '0;
          bit_d       = '0;
          pixel_d     = '0;
          pixel_max_d = limit_eff;
          mode32_d    = bus.reg_ctrl_32bit;
        end
      end

      ST_TRANSMIT: begin
        if (tx_active) begin
          if (pattern_of) begin
            pattern_d = '0;
            if (bit_of) begin
              bit_d = '0;
              if (pixel_of) begin
                pixel_d = '0;
                gap_d   = '0;
                state_d = ST_RESET;
              end else begin
                pixel_d = pixel_q + BUFFER_BITS'(1);
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end else begin
            pattern_d = pattern_q + PATTERN_BITS'(1);
          end
        end
      end

      ST_RESET: begin
        if (gap_active) begin
          if (gap_end) begin
            gap_d        = '0;
            frame_done_d = 1'b1;
            if (bus.reg_ctrl_loop) begin
              state_d     = ST_TRANSMIT;
              pattern_d   = '0;
              bit_d       = '0;
              pixel_d     = '0;
              pixel_max_d = limit_eff;
              mode32_d    = bus.reg_ctrl_32bit;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            gap_d = gap_q + RESET_BITS'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; init clears everything except the run history.
  always_ff @(posedge clk7mhz) begin
    if (!rstn) begin
      run_q        <= 1'b0;
      state_q      <= ST_IDLE;
      pattern_q    <= '0;
      bit_q        <= '0;
      pixel_q      <= '0;
      pixel_max_q  <= '0;
      mode32_q     <= 1'b0;
      gap_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      run_q <= bus.reg_ctrl_run;
      if (bus.reg_ctrl_init) begin
        state_q      <= ST_IDLE;
        pattern_q    <= '0;
        bit_q        <= '0;
        pixel_q      <= '0;
        pixel_max_q  <= '0;
        mode32_q     <= 1'b0;
        gap_q        <= '0;
        frame_done_q <= 1'b0;
      end else begin
        state_q      <= state_d;
        pattern_q    <= pattern_d;
        bit_q        <= bit_d;
        pixel_q      <= pixel_d;
        pixel_max_q  <= pixel_max_d;
        mode32_q     <= mode32_d;
        gap_q        <= gap_d;
        frame_done_q <= frame_done_d;
      end
    end
  end

`ifdef ANTON_STREAM_FRAME_COUNTER_EN
  logic [15:0] frame_count_q;

  // Completed-frame counter, stepping on the same edge that raises frame_done.
  always_ff @(posedge clk7mhz) begin
    if (!rstn) begin
      frame_count_q <= '0;
    end else if (bus.reg_ctrl_init) begin
      frame_count_q <= '0;
    end else if (frame_done_d) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign bus.frame_count = frame_count_q;
`else
  assign bus.frame_count = 16'd0;
`endif

  assign bus.state             = state_q;
  assign bus.bit_pattern_index = pattern_q;
  assign bus.pixel_bit_index   = bit_q;
  assign bus.pixel_index       = pixel_q;
  assign bus.pixel_index_max   = pixel_max_q;
  assign bus.stream_output     = tx_active;
  assign bus.stream_reset      = gap_active;
  assign bus.stream_pattern_of = pattern_of;
  assign bus.stream_bit_of     = bit_of;
  assign bus.stream_pixel_of   = pixel_of;
  assign bus.frame_done        = frame_done_q;

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// Self-checking bench for anton_neopixel_stream_sequencer.
// A frame-position model (linear cycle position within the frame, indices
// derived by division) is compared against the DUT on every negedge, and
// directed scenarios pin frame lengths and boundary values with literals.
// Honors ANTON_STREAM_FRAME_COUNTER_EN for the frame_count expectation.
module tb_anton_neopixel_stream_sequencer;

  localparam int BUFFER_END    = 15;
  localparam int PATTERN_STEPS = 8;
  localparam int RESET_CYCLES  = 350;
  localparam int BUFFER_BITS   = 4;
  localparam int PATTERN_BITS  = 3;
`ifdef ANTON_STREAM_FRAME_COUNTER_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic clk7mhz = 1'b0;
  logic rstn    = 1'b0;

  always #5 clk7mhz = ~clk7mhz;

  anton_neopixel_stream_sequencer_if #(
    .BUFFER_BITS (BUFFER_BITS),
    .PATTERN_BITS(PATTERN_BITS)
  ) bus ();

  anton_neopixel_stream_sequencer #(
    .BUFFER_END   (BUFFER_END),
    .PATTERN_STEPS(PATTERN_STEPS),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clk7mhz(clk7mhz),
    .rstn   (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  int cnt_out = 0, cnt_rst = 0, cnt_bit_of = 0, cnt_pix_of = 0, cnt_done = 0;

  // Model: state code, linear position in frame, gap position, latched frame shape.
  int m_state = 0, m_t = 0, m_r = 0, m_max = 0, m_count = 0;
  bit m_32 = 0, m_done = 0, m_runq = 0, m_started = 0;

  function automatic int limit_of(input bit lim_en, input int rmax);
    if (lim_en && rmax < BUFFER_END) return rmax;
    return BUFFER_END;
  endfunction

  function automatic int frame_len(input int max_idx, input bit is32);
    return (max_idx + 1) * (is32 ? 32 : 24) * PATTERN_STEPS;
  endfunction

  // Advance the frame-position model on each clock edge.
  always @(posedge clk7mhz) begin
    m_started <= 1'b1;
    if (!rstn) begin
      m_state <= 0; m_t <= 0; m_r <= 0; m_max <= 0; m_32 <= 0;
      m_done <= 0; m_count <= 0; m_runq <= 0;
    end else begin
      m_runq <= bus.reg_ctrl_run;
      if (bus.reg_ctrl_init) begin
        m_state <= 0; m_t <= 0; m_r <= 0; m_max <= 0; m_32 <= 0;
        m_done <= 0; m_count <= 0;
      end else begin
        m_done <= 0;
        if (m_state == 0) begin
          if (bus.reg_ctrl_run && (bus.reg_ctrl_loop || !m_runq)) begin
            m_state <= 1;
            m_t     <= 0;
            m_max   <= limit_of(bus.reg_ctrl_limit, int'(bus.reg_max));
            m_32    <= bus.reg_ctrl_32bit;
          end
        end else if (m_state == 1) begin
          if (bus.reg_ctrl_run) begin
            if (m_t + 1 == frame_len(m_max, m_32)) begin
              m_state <= 2; m_t <= 0; m_r <= 0;
            end else begin
              m_t <= m_t + 1;
            end
          end
        end else begin
          if (bus.reg_ctrl_run) begin
            if (m_r == RESET_CYCLES - 1) begin
              m_done  <= 1;
              m_count <= (m_count + 1) % 65536;
              m_r     <= 0;
              if (bus.reg_ctrl_loop) begin
                m_state <= 1;
                m_t     <= 0;
                m_max   <= limit_of(bus.reg_ctrl_limit, int'(bus.reg_max));
                m_32    <= bus.reg_ctrl_32bit;
              end else begin
                m_state <= 0;
              end
            end else begin
              m_r <= m_r + 1;
            end
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk7mhz);
    #1;
  endtask

  task automatic apply_stimulus(input bit run, input bit loop, input bit limit,
                                input bit is32, input int rmax);
    bus.reg_ctrl_run   = run;
    bus.reg_ctrl_loop  = loop;
    bus.reg_ctrl_limit = limit;
    bus.reg_ctrl_32bit = is32;
    bus.reg_max        = 13'(rmax);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_loop();
    int bits, per_pix, fl;
    bit act, e_out, e_rst;
    forever begin
      @(negedge clk7mhz);
      if (m_started) begin
        bits    = m_32 ? 32 : 24;
        per_pix = bits * PATTERN_STEPS;
        fl      = frame_len(m_max, m_32);
        act     = bus.reg_ctrl_run && !bus.reg_ctrl_init && rstn;
        e_out   = (m_state == 1) && act;
        e_rst   = (m_state == 2) && act;
        check_output("state", int'(bus.state), m_state);
        check_output("bit_pattern_index", int'(bus.bit_pattern_index), m_t % PATTERN_STEPS);
        check_output("pixel_bit_index", int'(bus.pixel_bit_index), (m_t / PATTERN_STEPS) % bits);
        check_output("pixel_index", int'(bus.pixel_index), m_t / per_pix);
        check_output("pixel_index_max", int'(bus.pixel_index_max), m_max);
        check_output("stream_output", int'(bus.stream_output), int'(e_out));
        check_output("stream_reset", int'(bus.stream_reset), int'(e_rst));
        check_output("stream_pattern_of", int'(bus.stream_pattern_of),
                     int'(e_out && (m_t % PATTERN_STEPS == PATTERN_STEPS - 1)));
        check_output("stream_bit_of", int'(bus.stream_bit_of),
                     int'(e_out && ((m_t + 1) % per_pix == 0)));
        check_output("stream_pixel_of", int'(bus.stream_pixel_of),
                     int'(e_out && (m_t + 1 == fl)));
        check_output("frame_done", int'(bus.frame_done), int'(m_done));
        check_output("frame_count", int'(bus.frame_count), FC_EN ? m_count : 0);
        cnt_out    += int'(bus.stream_output);
        cnt_rst    += int'(bus.stream_reset);
        cnt_bit_of += int'(bus.stream_bit_of);
        cnt_pix_of += int'(bus.stream_pixel_of);
        cnt_done   += int'(bus.frame_done);
      end
    end
  endtask

  initial begin
    int s_out, s_rst, s_bit, s_pix, s_done;
    bus.reg_ctrl_init = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 2);
    rstn = 1'b0;
    fork
      compare_loop();
    join_none

    // Reset with run already high, then release: edge start on the first edge.
    tick(3);
    check_output("reset_state", int'(bus.state), 0);
    check_output("reset_output", int'(bus.stream_output), 0);
    check_output("reset_pixel_max", int'(bus.pixel_index_max), 0);
    rstn = 1'b1;
    s_out = cnt_out; s_rst = cnt_rst; s_bit = cnt_bit_of; s_pix = cnt_pix_of; s_done = cnt_done;
    tick(1);
    check_output("start_state", int'(bus.state), 1);
    check_output("start_output", int'(bus.stream_output), 1);
    tick(576 + 350 + 4);
    check_output("f24_output_cycles", cnt_out - s_out, 576);
    check_output("f24_bit_of", cnt_bit_of - s_bit, 3);
    check_output("f24_pixel_of", cnt_pix_of - s_pix, 1);
    check_output("f24_reset_cycles", cnt_rst - s_rst, 350);
    check_output("f24_frame_done", cnt_done - s_done, 1);
    check_output("f24_back_idle", int'(bus.state), 0);

    // Pause for 10 cycles mid-frame; total active length must not change.
    bus.reg_ctrl_run = 1'b0;
    tick(2);
    bus.reg_ctrl_run = 1'b1;
    s_out = cnt_out;
    tick(1);
    tick(100);
    check_output("pause_pattern_before", int'(bus.bit_pattern_index), 4);
    check_output("pause_bit_before", int'(bus.pixel_bit_index), 12);
    bus.reg_ctrl_run = 1'b0;
    tick(10);
    check_output("pause_pattern_held", int'(bus.bit_pattern_index), 4);
    check_output("pause_bit_held", int'(bus.pixel_bit_index), 12);
    check_output("pause_state_held", int'(bus.state), 1);
    bus.reg_ctrl_run = 1'b1;
    tick(476 + 350 + 4);
    check_output("pause_output_cycles", cnt_out - s_out, 576);

    // 32-bit single pixel frame.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 0);
    tick(2);
    bus.reg_ctrl_run = 1'b1;
    s_out = cnt_out;
    tick(1);
    tick(255);
    check_output("f32_bit_index_31", int'(bus.pixel_bit_index), 31);
    check_output("f32_bit_of", int'(bus.stream_bit_of), 1);
    check_output("f32_pixel_of", int'(bus.stream_pixel_of), 1);
    tick(1);
    check_output("f32_enter_reset", int'(bus.state), 2);
    tick(350 + 4);
    check_output("f32_output_cycles", cnt_out - s_out, 256);

    // Clamp of an oversized reg_max, and latching against a mid-frame write.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8191);
    tick(2);
    bus.reg_ctrl_run = 1'b1;
    tick(1);
    check_output("clamp_max", int'(bus.pixel_index_max), 15);
    bus.reg_max = 13'd3;
    tick(50);
    check_output("latched_max", int'(bus.pixel_index_max), 15);
    tick(3022 + 354);
    check_output("clamp_frame_idle", int'(bus.state), 0);
    bus.reg_ctrl_run = 1'b0;
    tick(2);
    bus.reg_ctrl_run = 1'b1;
    tick(1);
    check_output("next_frame_max", int'(bus.pixel_index_max), 3);

    // Init in the middle of RESET.
    tick(768 + 9);
    check_output("init_pre_state", int'(bus.state), 2);
    bus.reg_ctrl_init = 1'b1;
    #1;
    check_output("init_cycle_reset_low", int'(bus.stream_reset), 0);
    check_output("init_cycle_output_low", int'(bus.stream_output), 0);
    tick(1);
    check_output("init_state_idle", int'(bus.state), 0);
    check_output("init_max_zero", int'(bus.pixel_index_max), 0);
    bus.reg_ctrl_init = 1'b0;
    tick(2);
    check_output("init_stays_idle", int'(bus.state), 0);

    // Looping single-pixel frames with the frame counter.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
    tick(1);
    check_output("loop_start", int'(bus.state), 1);
    tick(192);
    check_output("loop_gap_start", int'(bus.state), 2);
    tick(349);
    check_output("loop_gap_last", int'(bus.state), 2);
    tick(1);
    check_output("loop_retransmit", int'(bus.state), 1);
    check_output("loop_done_1", int'(bus.frame_done), 1);
    check_output("loop_count_1", int'(bus.frame_count), FC_EN ? 1 : 0);
    tick(191);
    check_output("loop_f2_tx", int'(bus.state), 1);
    tick(1);
    check_output("loop_f2_gap", int'(bus.state), 2);
    tick(350);
    check_output("loop_done_2", int'(bus.frame_done), 1);
    tick(542);
    check_output("loop_done_3", int'(bus.frame_done), 1);
    check_output("loop_count_3", int'(bus.frame_count), FC_EN ? 3 : 0);

    bus.reg_ctrl_init = 1'b1;
    tick(2);
    bus.reg_ctrl_init = 1'b0;
    bus.reg_ctrl_loop = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
